// File: rtl/app_scheduler.sv
// Top-level LED-board application scheduler: browse populated slots with the keys,
// launch one application, hold it enabled until it reports done or is aborted, then tear down.
module app_scheduler #(
  parameter int         N_APPS       = 8,
  parameter logic [7:0] APP_MASK     = 8'hFF,
  parameter int         TEARDOWN_CYC = 16,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] keys,
  input  logic [7:0] en_back,
  output logic [7:0] en_sub,
  output logic [2:0] sel,
  output logic       running,
  output logic       busy
);

  typedef enum logic [1:0] {
    MENU     = 2'd0,
    START    = 2'd1,
    RUN      = 2'd2,
    TEARDOWN = 2'd3
  } state_t;

  localparam logic [7:0] SLOT_RANGE = (N_APPS >= 8) ? 8'hFF : 8'((9'd1 << N_APPS) - 9'd1);
  localparam logic [7:0] MASK_EFF   = APP_MASK & SLOT_RANGE;
  localparam int         CNT_W      = (TEARDOWN_CYC > 1) ? $clog2(TEARDOWN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TEARDOWN_CYC - 1);
  localparam logic [2:0] LAST_SLOT  = 3'(N_APPS - 1);

  function automatic logic [2:0] lowest_slot(input logic [7:0] mask);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && mask[i]) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Walks around the ring (wrapping at N_APPS) to the nearest populated slot.
  function automatic logic [2:0] step_slot(input logic [2:0] cur, input logic fwd);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = cur;
    cand  = cur;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (fwd) begin
        cand = (cand == LAST_SLOT) ? 3'd0 : cand + 3'd1;
      end else begin
        cand = (cand == 3'd0) ? LAST_SLOT : cand - 3'd1;
      end
      if (!found && MASK_EFF[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  localparam logic [2:0] SEL_RST = lowest_slot(MASK_EFF);

  logic [SYNC_STAGES-1:0][3:0] key_sync_r;
  logic [SYNC_STAGES-1:0][7:0] back_sync_r;
  logic [3:0]       key_prev_r;
  logic             k_enter_r, k_next_r, k_prev_r, k_abort_r;
  logic [3:0]       key_edge_s;
  logic             back_s;
  logic             unused_keys_s;

  state_t           state_r, state_next_s;
  logic [2:0]       sel_r, sel_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [7:0]       en_sub_r;
  logic             running_r, busy_r;

  assign unused_keys_s = ^keys[5:3];
  assign key_edge_s    = key_sync_r[SYNC_STAGES-1] & ~key_prev_r;
  assign back_s        = |(back_sync_r[SYNC_STAGES-1] & (8'd1 << sel_r));

  // Input synchronizers and registered key rising-edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync_r  <= '0;
      back_sync_r <= '0;
      key_prev_r  <= 4'd0;
      k_enter_r   <= 1'b0;
      k_next_r    <= 1'b0;
      k_prev_r    <= 1'b0;
      k_abort_r   <= 1'b0;
    end else begin
      key_sync_r[0]  <= {keys[6], keys[2:0]};
      back_sync_r[0] <= en_back;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        key_sync_r[i]  <= key_sync_r[i-1];
        back_sync_r[i] <= back_sync_r[i-1];
      end
      key_prev_r <= key_sync_r[SYNC_STAGES-1];
      k_enter_r  <= key_edge_s[0];
      k_next_r   <= key_edge_s[1];
      k_prev_r   <= key_edge_s[2];
      k_abort_r  <= key_edge_s[3];
    end
  end

  // Next-state, selection and teardown-counter logic.
  always_comb begin
    state_next_s = state_r;
    sel_next_s   = sel_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      MENU: begin
        if (MASK_EFF == 8'h00) begin
          state_next_s = MENU;
        end else if (k_enter_r) begin
          // Enter always wins over browsing; it only launches when the slot is idle.
          if (MASK_EFF[sel_r] && !back_s) begin
            state_next_s = START;
          end else begin
            state_next_s = MENU;
          end
        end else if (k_next_r && !k_prev_r) begin
          sel_next_s = step_slot(sel_r, 1'b1);
        end else if (k_prev_r && !k_next_r) begin
          sel_next_s = step_slot(sel_r, 1'b0);
        end else begin
          sel_next_s = sel_r;
        end
      end
      START: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (back_s || k_abort_r) begin
          state_next_s = TEARDOWN;
          cnt_next_s   = CNT_LOAD;
        end else begin
          state_next_s = RUN;
        end
      end
      TEARDOWN: begin
        if (cnt_r == '0) begin
          state_next_s = MENU;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_next_s = MENU;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MENU;
      sel_r     <= SEL_RST;
      cnt_r     <= '0;
      en_sub_r  <= 8'hFF;
      running_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      sel_r     <= sel_next_s;
      cnt_r     <= cnt_next_s;
      en_sub_r  <= (state_next_s == RUN) ? ~(8'd1 << sel_next_s) : 8'hFF;
      running_r <= (state_next_s == RUN);
      busy_r    <= (state_next_s == START) || (state_next_s == TEARDOWN);
    end
  end

  assign en_sub  = en_sub_r;
  assign sel     = sel_r;
  assign running = running_r;
  assign busy    = busy_r;

endmodule
